// File: rtl/inst_loader_if.sv
// -----------------------------------------------------------------------------
// inst_loader_if
// Bundles the byte-stream handshake, the instruction-memory write port and the
// loader status lines of inst_loader.
//   master : host/bench side -- drives load_start, byte_valid, byte_data and
//            observes everything the loader produces
//   slave  : loader side     -- consumes the stream, drives byte_ready, the
//            memory write port (mem_we/mem_addr/mem_wdata) and the status
//            outputs cpu_hold/done/error
// -----------------------------------------------------------------------------
interface inst_loader_if;
   logic        load_start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_hold;
   logic        done;
   logic        error;

   modport master (
      output load_start, byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
   );

   modport slave (
      input  load_start, byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error
   );
endinterface

// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
// Loads an instruction image from a byte stream into instruction memory while
// holding the processor in reset. Stream format: 16-bit word count N (MSB
// first), then N instructions of 4 bytes each, instruction MSB first. Words
// are stored byte-swapped so the flipping ROM read path returns the original
// big-endian instruction.
//
// Ports:
//   clock  : system clock, all state on the rising edge
//   reset  : asynchronous active-low reset
//   bus    : inst_loader_if.slave
//            load_start/byte_valid/byte_data in, byte_ready out,
//            mem_we/mem_addr/mem_wdata write port, cpu_hold/done/error status
//
// Parameters:
//   ADDR_WIDTH : log2 of memory depth in words (max load 2**ADDR_WIDTH words)
//   BASE_ADDR  : word-aligned byte address of the first word written
//
// Optional feature macro: INST_LOADER_CHECKSUM_EN
//   When defined, a trailing byte equal to the XOR of all data bytes must
//   follow the last word (8'h00 when N=0); a mismatch ends in ERROR.
// -----------------------------------------------------------------------------
module inst_loader #(
   parameter int          ADDR_WIDTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
   input  logic          clock,
   input  logic          reset,
   inst_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_HI,
      S_HDR_LO,
      S_DATA,
      S_WRITE,
      S_DONE,
`ifdef INST_LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_ERROR
   } state_t;

   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

   state_t                state_q;
   logic [15:0]           n_q;
   logic [ADDR_WIDTH:0]   idx_q;       // one extra bit so N = 2**ADDR_WIDTH does not wrap
   logic [1:0]            byte_cnt_q;
   logic [23:0]           shift_q;     // holds {b2,b1,b0} until the fourth byte arrives
   logic                  ready_q;
   logic                  we_q;
   logic [31:0]           addr_q;
   logic [31:0]           wdata_q;
   logic                  hold_q;
   logic                  done_q;
   logic                  error_q;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [7:0]            xor_q;
   logic [7:0]            xor_d;
`endif

   logic                  xfer;
   logic [15:0]           n_d;
   logic [ADDR_WIDTH:0]   idx_d;
   logic                  last_word;

   assign xfer      = bus.byte_valid & ready_q;
   assign n_d       = {n_q[15:8], bus.byte_data};
   assign idx_d     = idx_q + 1'b1;
   assign last_word = (17'(idx_d) == {1'b0, n_q});
`ifdef INST_LOADER_CHECKSUM_EN
   assign xor_d     = xor_q ^ bus.byte_data;
`endif

   // byte_ready is registered, so it is set together with the state it
   // belongs to; it is high exactly in HDR_HI, HDR_LO, DATA (and CHK).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         n_q        <= '0;
         idx_q      <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= BASE_ADDR;
         wdata_q    <= '0;
         hold_q     <= 1'b1;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
`ifdef INST_LOADER_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         we_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.load_start) begin
                  state_q    <= S_HDR_HI;
                  ready_q    <= 1'b1;
                  done_q     <= 1'b0;
                  error_q    <= 1'b0;
                  hold_q     <= 1'b1;
                  idx_q      <= '0;
                  byte_cnt_q <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
                  xor_q      <= '0;
`endif
               end
            end
            S_HDR_HI: begin
               if (xfer) begin
                  n_q[15:8] <= bus.byte_data;
                  state_q   <= S_HDR_LO;
               end
            end
            S_HDR_LO: begin
               if (xfer) begin
                  n_q[7:0] <= bus.byte_data;
                  if (n_d == 16'd0) begin
`ifdef INST_LOADER_CHECKSUM_EN
                     state_q <= S_CHK;
`else
                     state_q <= S_DONE;
                     ready_q <= 1'b0;
                     done_q  <= 1'b1;
                     hold_q  <= 1'b0;
`endif
                  end else if ({1'b0, n_d} > MAX_WORDS) begin
                     state_q <= S_ERROR;
                     ready_q <= 1'b0;
                     error_q <= 1'b1;
                  end else begin
                     state_q <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (xfer) begin
                  shift_q    <= {bus.byte_data, shift_q[23:8]};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
                  xor_q      <= xor_d;
`endif
                  if (byte_cnt_q == 2'd3) begin
                     // {b3,b2,b1,b0}: stored swapped, undone by the ROM flip
                     wdata_q <= {bus.byte_data, shift_q};
                     addr_q  <= BASE_ADDR + (32'(idx_q) << 2);
                     we_q    <= 1'b1;
                     ready_q <= 1'b0;
                     state_q <= S_WRITE;
                  end
               end
            end
            S_WRITE: begin
               idx_q <= idx_d;
               if (last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
                  state_q <= S_CHK;
                  ready_q <= 1'b1;
`else
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  hold_q  <= 1'b0;
`endif
               end else begin
                  state_q <= S_DATA;
                  ready_q <= 1'b1;
               end
            end
`ifdef INST_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (xfer) begin
                  ready_q <= 1'b0;
                  if (bus.byte_data == xor_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     hold_q  <= 1'b0;
                  end else begin
                     state_q <= S_ERROR;
                     error_q <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.byte_ready = ready_q;
   assign bus.mem_we     = we_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.cpu_hold   = hold_q;
   assign bus.done       = done_q;
   assign bus.error      = error_q;

endmodule
